writeback_unit: RTL

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit_if.sv | 40 ++++
 rtl/writeback_unit.sv | 74 +++++++
 2 files changed

// File: rtl/writeback_unit_if.sv
// writeback_unit_if: M-stage capture, flush/counter control and W-stage result bundle
interface writeback_unit_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_THREADS = 4,
  parameter int COUNT_WIDTH = 32
);
  localparam int BITS_THREADS = $clog2(NUM_THREADS);
  logic valid_m;
  logic reg_write_m;
  logic [1:0] result_src_m;
  logic [2:0] funct3_m;
  logic [DATA_WIDTH-1:0] alu_result_m;
  logic [DATA_WIDTH-1:0] read_data_m;
  logic [DATA_WIDTH-1:0] imm_m;
  logic [4:0] rd_m;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_m;
  logic [BITS_THREADS-1:0] tid_m;
  logic flush_valid;
  logic [BITS_THREADS-1:0] flush_tid;
  logic cnt_clr;
  logic [BITS_THREADS-1:0] cnt_clr_tid;
  logic [BITS_THREADS-1:0] cnt_rd_tid;
  logic valid_w;
  logic reg_write_w;
  logic [DATA_WIDTH-1:0] result_w;
  logic [4:0] rd_w;
  logic [BITS_THREADS-1:0] tid_w;
  logic [COUNT_WIDTH-1:0] cnt_rd_data;
  modport master (
    output valid_m, reg_write_m, result_src_m, funct3_m, alu_result_m, read_data_m, imm_m,
           rd_m, pc_plus4_m, tid_m, flush_valid, flush_tid, cnt_clr, cnt_clr_tid, cnt_rd_tid,
    input  valid_w, reg_write_w, result_w, rd_w, tid_w, cnt_rd_data
  );
  modport slave (
    input  valid_m, reg_write_m, result_src_m, funct3_m, alu_result_m, read_data_m, imm_m,
           rd_m, pc_plus4_m, tid_m, flush_valid, flush_tid, cnt_clr, cnt_clr_tid, cnt_rd_tid,
    output valid_w, reg_write_w, result_w, rd_w, tid_w, cnt_rd_data
  );
endinterface

// File: rtl/writeback_unit.sv
// writeback_unit: barrel-thread W stage with load extraction and per-thread retire counters
module writeback_unit #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_THREADS = 4,
  parameter int COUNT_WIDTH = 32
) (
  input logic clk,
  input logic rst_n,
  writeback_unit_if.slave wb_io
);
  localparam int BITS_THREADS = $clog2(NUM_THREADS);
  localparam int OFF = $clog2(DATA_WIDTH / 8);
  logic live;
  logic [OFF-1:0] off_b, off_h, off_w;
  logic [DATA_WIDTH-1:0] sh_b, sh_h, sh_w, load_d, result_d, result_q;
  logic valid_q, reg_write_q;
  logic [4:0] rd_q;
  logic [BITS_THREADS-1:0] tid_q;
  logic [COUNT_WIDTH-1:0] cnt_q [NUM_THREADS];
  logic [COUNT_WIDTH-1:0] cnt_d [NUM_THREADS];
  assign live = wb_io.valid_m && !(wb_io.flush_valid && wb_io.flush_tid == wb_io.tid_m);
  // Misaligned offsets are silently rounded down to the access size
  assign off_b = wb_io.alu_result_m[OFF-1:0];
  assign off_h = off_b & ~OFF'(1);
  assign off_w = off_b & ~OFF'(3);
  assign sh_b = wb_io.read_data_m >> {off_b, 3'b000};
  assign sh_h = wb_io.read_data_m >> {off_h, 3'b000};
  assign sh_w = wb_io.read_data_m >> {off_w, 3'b000};
  always_comb begin
    case (wb_io.funct3_m)
      3'b000: load_d = DATA_WIDTH'($signed(sh_b[7:0]));
      3'b001: load_d = DATA_WIDTH'($signed(sh_h[15:0]));
      3'b010: load_d = DATA_WIDTH'($signed(sh_w[31:0]));
      3'b100: load_d = DATA_WIDTH'(sh_b[7:0]);
      3'b101: load_d = DATA_WIDTH'(sh_h[15:0]);
      3'b110: load_d = DATA_WIDTH'(sh_w[31:0]);
      default: load_d = wb_io.read_data_m;
    endcase
  end
  always_comb
    result_d = wb_io.result_src_m == 2'd0 ? wb_io.alu_result_m :
               wb_io.result_src_m == 2'd1 ? load_d :
               wb_io.result_src_m == 2'd2 ? DATA_WIDTH'(wb_io.pc_plus4_m) : wb_io.imm_m;
  // Clear is applied last so it beats a same-thread increment
  always_comb begin
    cnt_d = cnt_q;
    if (live) cnt_d[wb_io.tid_m] = cnt_q[wb_io.tid_m] + COUNT_WIDTH'(1);
    if (wb_io.cnt_clr) cnt_d[wb_io.cnt_clr_tid] = '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      reg_write_q <= 1'b0;
      result_q <= '0;
      rd_q <= '0;
      tid_q <= '0;
      cnt_q <= '{default: '0};
    end else begin
      valid_q <= live;
      reg_write_q <= live && wb_io.reg_write_m && wb_io.rd_m != 5'd0;
      result_q <= result_d;
      rd_q <= wb_io.rd_m;
      tid_q <= wb_io.tid_m;
      cnt_q <= cnt_d;
    end
  end
  assign wb_io.valid_w = valid_q;
  assign wb_io.reg_write_w = reg_write_q;
  assign wb_io.result_w = result_q;
  assign wb_io.rd_w = rd_q;
  assign wb_io.tid_w = tid_q;
  assign wb_io.cnt_rd_data = cnt_q[wb_io.cnt_rd_tid];
endmodule
